// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types and default parameter values for the pipeline flow controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } flow_state_t;

  localparam int STAGE_IDX_W = 8;
  typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

  localparam int NSTAGE_DEF    = 5;
  localparam int BR_STAGE_DEF  = 1;
  localparam int BR_KILL_DEF   = 1;
  localparam int EXC_STAGE_DEF = 3;
  localparam int ADDR_W_DEF    = 32;
  localparam int TIMEOUT_DEF   = 1023;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Request/control bundle between the pipeline datapath and its flow controller.
interface pipe_flow_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [NSTAGE-1:0] stall_req;
  logic              mem_busy;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_target;

  logic [NSTAGE-1:0] stage_wr;
  logic [NSTAGE-1:0] stage_flush;
  logic              wb_diswr;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              icache_flush;
  logic              dcache_flush;
  logic              stall_timeout;

  modport master (
    input  stall_req, mem_busy, br_valid, br_target, exc_valid, exc_target,
    output stage_wr, stage_flush, wb_diswr, redir_valid, redir_target,
           icache_flush, dcache_flush, stall_timeout
  );

  modport slave (
    output stall_req, mem_busy, br_valid, br_target, exc_valid, exc_target,
    input  stage_wr, stage_flush, wb_diswr, redir_valid, redir_target,
           icache_flush, dcache_flush, stall_timeout
  );
endinterface

// File: rtl/pipe_flow_ctrl_stall_watchdog.sv
// Counts consecutive frozen/stalled cycles and raises a sticky flag at TIMEOUT.
module stall_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic resetn,
  input  logic active,
  output logic timeout
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == LIMIT) ? val : val + 1'b1;
  endfunction

  always_comb begin
    cnt_nxt = active ? sat_inc(cnt) : '0;
  end

  // flag tracks the next count so it is visible in the cycle cnt reaches the bound
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      timeout <= timeout | (cnt_nxt == LIMIT);
    end
  end
endmodule

// File: rtl/pipe_flow_ctrl.sv
// Resolves stalls, cache freezes, mispredicts and exceptions into per-stage
// write-enables, flushes and a PC redirect; freeze-time branches are replayed.
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = NSTAGE_DEF,
  parameter int BR_STAGE  = BR_STAGE_DEF,
  parameter int BR_KILL   = BR_KILL_DEF,
  parameter int EXC_STAGE = EXC_STAGE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  pipe_flow_ctrl_if.master bus
);

  function automatic logic [NSTAGE-1:0] span_mask(input int lo, input int hi);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NSTAGE-1:0] KILL_MASK = span_mask(BR_STAGE, BR_STAGE + BR_KILL - 1);
  localparam logic [NSTAGE-1:0] EXC_MASK  = span_mask(1, EXC_STAGE);

  flow_state_t       state;
  flow_state_t       state_nxt;
  logic [ADDR_W-1:0] pend_pc;
  logic [ADDR_W-1:0] pend_pc_nxt;

  logic              stall_any;
  stage_idx_t        stall_top;
  logic [NSTAGE-1:0] hold_mask;
  logic [NSTAGE-1:0] bubble_mask;
  logic              br_held;
  logic              take_br;

  always_comb begin
    stall_any = |bus.stall_req;
    stall_top = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (bus.stall_req[i]) stall_top = stage_idx_t'(i);
    end
    hold_mask   = '0;
    bubble_mask = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      hold_mask[i]   = stall_any && (stage_idx_t'(i) <= stall_top);
      bubble_mask[i] = stall_any && (stage_idx_t'(i) == stall_top + 1'b1);
    end
    br_held = stall_any && (stall_top >= stage_idx_t'(BR_STAGE));
  end

  always_comb begin
    bus.stage_wr     = '0;
    bus.stage_flush  = '0;
    bus.wb_diswr     = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = '0;
    bus.icache_flush = 1'b0;
    bus.dcache_flush = 1'b0;
    state_nxt        = state;
    pend_pc_nxt      = pend_pc;
    take_br          = 1'b0;

    if (!resetn) begin
      bus.stage_flush = '1;
      bus.wb_diswr    = 1'b1;
    end else if (bus.exc_valid) begin
      bus.stage_wr     = '1;
      bus.stage_flush  = EXC_MASK;
      bus.redir_valid  = 1'b1;
      bus.redir_target = bus.exc_target;
      bus.icache_flush = 1'b1;
      bus.dcache_flush = 1'b1;
      state_nxt        = RUN;
    end else if (bus.mem_busy) begin
      bus.wb_diswr = 1'b1;
      if (bus.br_valid && state == RUN) begin
        pend_pc_nxt = bus.br_target;
        state_nxt   = PEND;
      end
    end else begin
      bus.stage_wr    = ~hold_mask;
      bus.stage_flush = bubble_mask;
      // a replayed branch fires in the first unfrozen cycle, whatever the stall state
      take_br = (state == PEND) || (bus.br_valid && !br_held);
      if (take_br) begin
        bus.redir_valid  = 1'b1;
        bus.redir_target = (state == PEND) ? pend_pc : bus.br_target;
        bus.stage_flush  = bubble_mask | KILL_MASK;
        bus.stage_wr[0]  = 1'b1;
        bus.icache_flush = 1'b1;
        state_nxt        = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  stall_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .active (bus.mem_busy | (|bus.stall_req)),
    .timeout(bus.stall_timeout)
  );

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Parametrised pipeline write-enable/flush controller for the in-order MIPS pipeline, generalised from a fixed 5-stage layout to NSTAGE stages. It resolves per-stage stall requests, cache freezes, branch mispredicts and exceptions into per-stage register write-enables, flushes and a PC redirect. Unlike the previous generation, a branch redirect that arrives during a cache freeze is latched and replayed, never dropped. A stall watchdog flags pipelines frozen longer than a bound.

## Interface
- NSTAGE, 5: pipeline registers; index 0 = PC, NSTAGE-1 = MEM/WB.
- BR_STAGE, 1: stage whose register holds a resolving branch (ID); must be ≥1.
- BR_KILL, 1: stages BR_STAGE..BR_STAGE+BR_KILL-1 are flushed on mispredict; delay slot is preserved.
- EXC_STAGE, 3: exception commit stage; stages 1..EXC_STAGE are flushed.
- ADDR_W, 32: redirect target width.
- TIMEOUT, 1023: watchdog bound in cycles, ≥1.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- stall_req  in  NSTAGE  stage i cannot accept new input (load-use hazard, mul/div busy).
- mem_busy  in  1  I$ or D$ busy; freezes whole pipeline.
- br_valid  in  1  mispredict resolved at BR_STAGE.
- br_target  in  ADDR_W  correct PC.
- exc_valid  in  1  exception committing at EXC_STAGE.
- exc_target  in  ADDR_W  handler PC.
- stage_wr  out  NSTAGE  write enable of register i.
- stage_flush  out  NSTAGE  clear register i to bubble.
- wb_diswr  out  1  suppress register-file write this cycle.
- redir_valid  out  1  load PC with redir_target.
- redir_target  out  ADDR_W  redirect PC.
- icache_flush, dcache_flush  out  1 each  abort outstanding cache request.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- Priority: exception > mem_busy > stall > branch.
- Exception (exc_valid=1): all stage_wr=1; stage_flush[1..EXC_STAGE]=1; redir=exc_target; icache_flush=dcache_flush=1; pending branch discarded; state→RUN. Applies even while mem_busy=1; wb_diswr=0.
- Freeze (mem_busy=1, no exception): stage_wr=0, stage_flush=0, wb_diswr=1, redir_valid=0. If br_valid=1 and state RUN: latch br_target into pend_pc, state→PEND.
- Stall: s = highest i with stall_req[i]=1. stage_wr[0..s]=0, other stage_wr=1; stage_flush[s+1]=1 if s<NSTAGE-1. Branch is not taken this cycle unless s<BR_STAGE.
- Branch (br_valid, not frozen, not held by stall): redir=br_target; stage_flush[BR_STAGE..BR_STAGE+BR_KILL-1]=1 (clipped to NSTAGE-1); stage_wr[0]=1; icache_flush=1.
- PEND state, mem_busy=0: redirect=pend_pc and branch flushes as above, taking effect even if br_valid=1 (same event, never issued twice from pending); state→RUN. A br_valid seen in PEND is not re-latched.
- Watchdog: cnt increments on each cycle with mem_busy or any stall_req, clears otherwise; saturates at TIMEOUT; stall_timeout set when cnt==TIMEOUT, cleared only by reset.

## Timing
- All outputs combinational from inputs and registered state (state, pend_pc, cnt, stall_timeout); no added latency. A replayed branch redirects in the first cycle mem_busy=0.
- While resetn=0: stage_wr=0, stage_flush=all 1, redir_valid=0, cache flushes 0, wb_diswr=1. Registered state after reset: RUN, pend_pc=0, cnt=0, stall_timeout=0.
- Reset asserted while in PEND discards the pending branch.
- cnt width $clog2(TIMEOUT+1); no wrap.
- Exception and br_valid in the same cycle: exception wins, branch is not latched.

## Structure
- Package pipe_ctrl_pkg: state enum {RUN, PEND}, stage index typedef, default parameter constants.
- One submodule, stall_watchdog (counter + sticky flag), parametrised by TIMEOUT.

## Test plan
- stall_req=5'b00010, NSTAGE=5 -> stage_wr=5'b11100, stage_flush=5'b00100.
- br_valid, br_target=0xBFC0_0100, mem_busy=1 for 3 cycles -> no redirect while frozen; in cycle 4 (mem_busy=0) redir_valid=1, target 0xBFC0_0100, stage_flush[1]=1, exactly one redirect.
- exc_valid with mem_busy=1 and PEND active -> redir=exc_target, stage_flush=5'b01110, dcache_flush=1, pending dropped, wb_diswr=0.
- exc_valid and br_valid same cycle -> only exc_target issued; state RUN next cycle.
- TIMEOUT=4, mem_busy held 6 cycles -> stall_timeout rises at cycle 5 and stays high after mem_busy=0 until resetn=0.
- resetn=0 mid-PEND then released with mem_busy=0 -> no redirect, state RUN.
